// File: rtl/ppg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppg_pkg
// Description : Shared widths, reset constants and FSM encodings for the
//               PPG window statistics block.
// Revision    : 1.0 - initial release
// ============================================================================
package ppg_pkg;

    localparam int ADC_W = 8;
    localparam int SUM_W = 16;
    localparam int CNT_W = 9;

    localparam logic [ADC_W-1:0] MIN_INIT = 8'd255;
    localparam logic [ADC_W-1:0] MAX_INIT = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    // Window length N = 2^log2w expressed in counter width.
    function automatic logic [CNT_W-1:0] window_len(input int log2w);
        return CNT_W'(1) << log2w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppg_channel_acc.sv
`default_nettype none
// ============================================================================
// Module      : ppg_channel_acc
// Description : Per-channel min/max/sum accumulator over an N-sample window.
// Revision    : 1.0 - initial release
// ============================================================================
module ppg_channel_acc
    import ppg_pkg::*;
(
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             sample_stb,
    input  logic [ADC_W-1:0] sample,
    input  logic             clear,
    input  logic [CNT_W-1:0] N,
    output logic [ADC_W-1:0] min,
    output logic [ADC_W-1:0] max,
    output logic [SUM_W-1:0] sum,
    output logic             full
);

    logic [ADC_W-1:0] r_min;
    logic [ADC_W-1:0] r_max;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full_now;
    logic             w_last;
    logic             w_accept;
    logic [CNT_W-1:0] w_n_minus_1;

    assign w_n_minus_1 = N - CNT_W'(1);
    assign w_full_now  = (r_cnt == N);
    assign w_last      = (r_cnt == w_n_minus_1);
    assign w_accept    = sample_stb & ~w_full_now;

    // Look-ahead: also reports full when this cycle's sample completes the
    // window, so the controller can leave COLLECT on the same edge.
    assign full = w_full_now | (w_accept & w_last & ~clear);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= MIN_INIT;
            r_max <= MAX_INIT;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            // A sample arriving with clear starts the next window.
            if (sample_stb) begin
                r_min <= sample;
                r_max <= sample;
                r_sum <= SUM_W'(sample);
                r_cnt <= CNT_W'(1);
            end else begin
                r_min <= MIN_INIT;
                r_max <= MAX_INIT;
                r_sum <= '0;
                r_cnt <= '0;
            end
        end else if (w_accept) begin
            if (sample <= r_min) begin
                r_min <= sample;
            end
            if (sample >= r_max) begin
                r_max <= sample;
            end
            r_sum <= r_sum + SUM_W'(sample);
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign min = r_min;
    assign max = r_max;
    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/ppg_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : ppg_window_stats
// Description : Captures RED/IR samples on LED falling edges and publishes
//               per-channel AC (peak-to-peak) and DC (mean) per window.
// Revision    : 1.0 - initial release
// ============================================================================
module ppg_window_stats
    import ppg_pkg::*;
#(
    parameter int LOG2_WINDOW = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             Stats_En,
    input  logic             LED_RED,
    input  logic             LED_IR,
    input  logic [ADC_W-1:0] RED_ADC_Value,
    input  logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] RED_AC,
    output logic [ADC_W-1:0] RED_DC,
    output logic [ADC_W-1:0] IR_AC,
    output logic [ADC_W-1:0] IR_DC,
    output logic             Stats_Valid,
    output logic [7:0]       Window_Count
);

    localparam logic [CNT_W-1:0] C_N = window_len(LOG2_WINDOW);

    state_t r_state;
    state_t w_state_next;

    logic r_led_red_d;
    logic r_led_ir_d;

    logic w_red_fall;
    logic w_ir_fall;
    logic w_stb_en;
    logic w_acc_clear;
    logic w_publish;

    logic [ADC_W-1:0] w_red_min;
    logic [ADC_W-1:0] w_red_max;
    logic [SUM_W-1:0] w_red_sum;
    logic             w_red_full;
    logic [ADC_W-1:0] w_ir_min;
    logic [ADC_W-1:0] w_ir_max;
    logic [SUM_W-1:0] w_ir_sum;
    logic             w_ir_full;

    logic [ADC_W-1:0] r_red_ac;
    logic [ADC_W-1:0] r_red_dc;
    logic [ADC_W-1:0] r_ir_ac;
    logic [ADC_W-1:0] r_ir_dc;
    logic             r_stats_valid;
    logic [7:0]       r_window_count;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_led_red_d <= 1'b0;
            r_led_ir_d  <= 1'b0;
        end else begin
            r_led_red_d <= LED_RED;
            r_led_ir_d  <= LED_IR;
        end
    end

    assign w_red_fall = r_led_red_d & ~LED_RED;
    assign w_ir_fall  = r_led_ir_d  & ~LED_IR;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_clear  = 1'b0;
        w_stb_en     = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_acc_clear = 1'b1;
                if (Stats_En) begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Abort takes priority over a completing window.
                if (!Stats_En) begin
                    w_acc_clear  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stb_en = 1'b1;
                    if (w_red_full && w_ir_full) begin
                        w_state_next = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                w_publish    = 1'b1;
                w_acc_clear  = 1'b1;
                w_stb_en     = Stats_En;
                w_state_next = Stats_En ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                w_acc_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    ppg_channel_acc u_red_acc (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .sample_stb (w_red_fall & w_stb_en),
        .sample     (RED_ADC_Value),
        .clear      (w_acc_clear),
        .N          (C_N),
        .min        (w_red_min),
        .max        (w_red_max),
        .sum        (w_red_sum),
        .full       (w_red_full)
    );

    ppg_channel_acc u_ir_acc (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .sample_stb (w_ir_fall & w_stb_en),
        .sample     (IR_ADC_Value),
        .clear      (w_acc_clear),
        .N          (C_N),
        .min        (w_ir_min),
        .max        (w_ir_max),
        .sum        (w_ir_sum),
        .full       (w_ir_full)
    );

    // Only the mean byte of each sum is published.
    logic w_unused_sum;
    assign w_unused_sum = ^{w_red_sum, w_ir_sum};

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_red_ac       <= '0;
            r_red_dc       <= '0;
            r_ir_ac        <= '0;
            r_ir_dc        <= '0;
            r_stats_valid  <= 1'b0;
            r_window_count <= '0;
        end else begin
            r_stats_valid <= w_publish;
            if (w_publish) begin
                r_red_ac       <= w_red_max - w_red_min;
                r_red_dc       <= w_red_sum[LOG2_WINDOW +: ADC_W];
                r_ir_ac        <= w_ir_max - w_ir_min;
                r_ir_dc        <= w_ir_sum[LOG2_WINDOW +: ADC_W];
                r_window_count <= r_window_count + 8'd1;
            end
        end
    end

    assign RED_AC       = r_red_ac;
    assign RED_DC       = r_red_dc;
    assign IR_AC        = r_ir_ac;
    assign IR_DC        = r_ir_dc;
    assign Stats_Valid  = r_stats_valid;
    assign Window_Count = r_window_count;

endmodule
`default_nettype wire

// File: tb/tb_ppg_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppg_window_stats
// Description : Directed self-checking bench for ppg_window_stats (N = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppg_window_stats;

    logic       CLK;
    logic       rst_n;
    logic       Stats_En;
    logic       LED_RED;
    logic       LED_IR;
    logic [7:0] RED_ADC_Value;
    logic [7:0] IR_ADC_Value;
    logic [7:0] RED_AC;
    logic [7:0] RED_DC;
    logic [7:0] IR_AC;
    logic [7:0] IR_DC;
    logic       Stats_Valid;
    logic [7:0] Window_Count;

    int n_checks = 0;
    int n_errors = 0;
    int v_cnt    = 0;
    int n_double = 0;
    int exp_v    = 0;
    logic prev_valid = 1'b0;

    ppg_window_stats #(.LOG2_WINDOW(2)) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .Stats_En      (Stats_En),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .RED_AC        (RED_AC),
        .RED_DC        (RED_DC),
        .IR_AC         (IR_AC),
        .IR_DC         (IR_DC),
        .Stats_Valid   (Stats_Valid),
        .Window_Count  (Window_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        prev_valid <= Stats_Valid;
        if (Stats_Valid) begin
            v_cnt <= v_cnt + 1;
            if (prev_valid) n_double <= n_double + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_out(input string tag, input int rac, input int rdc, input int iac, input int idc, input int wc);
        check_val({tag, "_red_ac"}, RED_AC, rac);
        check_val({tag, "_red_dc"}, RED_DC, rdc);
        check_val({tag, "_ir_ac"},  IR_AC,  iac);
        check_val({tag, "_ir_dc"},  IR_DC,  idc);
        check_val({tag, "_wcnt"},   Window_Count, wc);
    endtask

    task automatic pulse_red(input logic [7:0] v);
        @(negedge CLK) LED_RED = 1'b1;
        @(negedge CLK) begin LED_RED = 1'b0; RED_ADC_Value = v; end
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        @(negedge CLK) LED_IR = 1'b1;
        @(negedge CLK) begin LED_IR = 1'b0; IR_ADC_Value = v; end
    endtask

    task automatic pulse_both(input logic [7:0] r, input logic [7:0] i);
        @(negedge CLK) begin LED_RED = 1'b1; LED_IR = 1'b1; end
        @(negedge CLK) begin
            LED_RED = 1'b0; LED_IR = 1'b0;
            RED_ADC_Value = r; IR_ADC_Value = i;
        end
    endtask

    task automatic pair(input logic [7:0] r, input logic [7:0] i);
        pulse_red(r);
        pulse_ir(i);
    endtask

    task automatic wait_valid(input int target, input string tag);
        int waited = 0;
        while (v_cnt < target && waited < 60) begin
            @(negedge CLK);
            waited++;
        end
        check_val(tag, v_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge CLK) rst_n = 1'b0;
        @(negedge CLK);
        check_out("reset", 0, 0, 0, 0, 0);
        check_val("reset_valid", Stats_Valid, 0);
        @(negedge CLK) rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; Stats_En = 1'b0; LED_RED = 1'b0; LED_IR = 1'b0;
        RED_ADC_Value = 8'd0; IR_ADC_Value = 8'd0;
        repeat (2) @(negedge CLK);
        check_out("por", 0, 0, 0, 0, 0);
        check_val("por_valid", Stats_Valid, 0);
        rst_n = 1'b1; Stats_En = 1'b1;

        // Publish a window, then reset mid-way through the next one.
        repeat (4) pair(8'd200, 8'd200);
        exp_v++; wait_valid(exp_v, "pre_wait");
        check_out("pre", 0, 200, 0, 200, 1);
        repeat (2) pair(8'd250, 8'd250);
        do_reset();

        // Basic window with exact publish latency.
        pair(8'd100, 8'd50); pair(8'd120, 8'd50); pair(8'd110, 8'd50);
        repeat (4) @(negedge CLK);
        check_val("fresh_no_pub", v_cnt, exp_v);
        pulse_red(8'd130); pulse_ir(8'd50);
        @(negedge CLK);
        check_val("lat_k_valid", Stats_Valid, 0);
        @(negedge CLK);
        check_val("lat_k1_valid", Stats_Valid, 1);
        check_out("basic", 30, 115, 0, 50, 1);
        @(negedge CLK);
        check_val("pulse_width", Stats_Valid, 0);
        exp_v++;

        // RED overfills before IR completes.
        pulse_red(8'd200); pulse_red(8'd210); pulse_red(8'd220);
        pulse_red(8'd230); pulse_red(8'd0);   pulse_red(8'd0);
        pulse_ir(8'd10); pulse_ir(8'd20); pulse_ir(8'd30); pulse_ir(8'd40);
        exp_v++; wait_valid(exp_v, "ovf_wait");
        check_out("ovf", 30, 215, 30, 25, 2);

        // Full-scale values.
        repeat (4) pair(8'd255, 8'd0);
        exp_v++; wait_valid(exp_v, "fs_wait");
        check_out("fs", 0, 255, 0, 0, 3);

        // Abort after two samples, then a clean window of 80s.
        do_reset();
        repeat (2) pair(8'd200, 8'd200);
        @(negedge CLK) Stats_En = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("abort_no_pub", v_cnt, exp_v);
        Stats_En = 1'b1;
        repeat (4) pair(8'd80, 8'd80);
        exp_v++; wait_valid(exp_v, "abort_wait");
        check_out("abort", 0, 80, 0, 80, 1);

        // Simultaneous edges; an IR sample lands in the PUBLISH cycle.
        pulse_both(8'd10, 8'd5); pulse_both(8'd20, 8'd5); pulse_both(8'd30, 8'd5);
        pulse_ir(8'd5);
        @(negedge CLK) begin LED_RED = 1'b1; LED_IR = 1'b1; end
        @(negedge CLK) begin LED_RED = 1'b0; RED_ADC_Value = 8'd40; end
        @(negedge CLK) begin LED_IR = 1'b0; IR_ADC_Value = 8'd99; end
        @(negedge CLK);
        check_val("sim1_valid", Stats_Valid, 1);
        check_out("sim1", 30, 25, 0, 5, 2);
        exp_v++;
        pulse_both(8'd60, 8'd100); pulse_both(8'd60, 8'd101); pulse_both(8'd60, 8'd102);
        pulse_red(8'd60);
        exp_v++; wait_valid(exp_v, "sim2_wait");
        check_out("sim2", 0, 60, 3, 100, 3);

        // Stats_En drops during PUBLISH: publish completes, then idle.
        repeat (4) pulse_both(8'd70, 8'd70);
        @(negedge CLK) Stats_En = 1'b0;
        @(negedge CLK);
        check_val("pubdrop_valid", Stats_Valid, 1);
        check_out("pubdrop", 0, 70, 0, 70, 4);
        exp_v++;
        repeat (4) pulse_both(8'd1, 8'd1);
        repeat (4) @(negedge CLK);
        check_val("idle_no_pub", v_cnt, exp_v);
        check_val("idle_hold_dc", RED_DC, 70);
        Stats_En = 1'b1;

        // Run to Window_Count wrap.
        for (int i = 0; i < 252; i++) begin
            repeat (4) pulse_both(8'(i), 8'(i));
            exp_v++; wait_valid(exp_v, "wrap_wait");
            if (i == 250) check_val("wcnt_255", Window_Count, 255);
        end
        check_val("wcnt_wrap", Window_Count, 0);
        repeat (2) @(negedge CLK);
        check_val("no_double_pulse", n_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppg_window_stats.md
# ppg_window_stats

Downstream of the LED/gain controller. Captures one RED and one IR sample per LED phase from the controller's `RED_ADC_Value` and `IR_ADC_Value`. Accumulates per-channel min, max and sum over a power-of-two window, then publishes AC (peak-to-peak) and DC (mean) per channel for the SpO2 ratio stage.

## Interface

**Parameters**
- `LOG2_WINDOW`, default 8: window length N = 2^LOG2_WINDOW samples per channel. Legal range 1..8.

**Ports**
- `CLK` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Stats_En` in 1: high = collect; low = abort and idle.
- `LED_RED` in 1: RED LED state from the controller.
- `LED_IR` in 1: IR LED state from the controller.
- `RED_ADC_Value` in 8: latest RED sample.
- `IR_ADC_Value` in 8: latest IR sample.
- `RED_AC` out 8: RED max − min of the last window.
- `RED_DC` out 8: RED sum >> LOG2_WINDOW.
- `IR_AC` out 8: IR max − min of the last window.
- `IR_DC` out 8: IR sum >> LOG2_WINDOW.
- `Stats_Valid` out 1: one-cycle pulse when new results are loaded.
- `Window_Count` out 8: windows published since reset; wraps 255→0.

## Operation

- **Sample capture:** `LED_RED` and `LED_IR` are registered internally (`_d`).
  - RED sample = `RED_ADC_Value` in a cycle where `LED_RED_d`=1 and `LED_RED`=0 (falling edge).
  - IR sample is captured the same way on the `LED_IR` falling edge.
  - Both edges in one cycle: both samples taken.
- **Per-channel accumulator:**
  - `min` is reset to 255, `max` to 0, `sum` (16 bit) to 0, `cnt` (9 bit) to 0.
  - A sample updates min and max (inclusive compare), adds to sum, and increments cnt.
  - A channel with cnt = N ignores further samples until the window is published.
- **FSM:**
  - `IDLE`: accumulators held cleared. `Stats_En`=1 → `COLLECT`.
  - `COLLECT`: accumulate. Both cnt = N → `PUBLISH`. `Stats_En`=0 → `IDLE`, accumulators cleared, outputs unchanged.
  - `PUBLISH`: one cycle. Sets AC = max − min and DC = sum[LOG2_WINDOW+7:LOG2_WINDOW], pulses `Stats_Valid`, increments `Window_Count`, clears accumulators. Then → `COLLECT` if `Stats_En`=1, else `IDLE`.
- **Samples arriving in the `PUBLISH` cycle** count as the first sample of the next window: the accumulator is cleared and loaded with that sample in the same edge.
- **Arithmetic:** AC never underflows, because max ≥ min is guaranteed when cnt = N ≥ 1. Sum max is 256·255 = 65280 and fits 16 bit. DC truncates, no rounding.
- **Results** hold between publishes.

## Timing

- **Reset values:** all outputs 0, FSM `IDLE`, `LED_*_d`=0, accumulators cleared. Reset mid-window discards all partial data.
- **Capture latency:** the sample is registered on the edge at which the falling edge is seen.
- **Publish latency:** the completing sample is captured at edge k. The FSM is `PUBLISH` after edge k. Outputs update and `Stats_Valid` goes high after edge k+1 and stay high exactly one cycle.
- **Stats_En falling mid-`PUBLISH`:** publish still completes, then → `IDLE`.
- **Throughput:** with the controller at 10 cycles per LED phase, one window = 20·N cycles.

## Structure

- `ppg_pkg` holds:
  - FSM encodings `ST_IDLE`, `ST_COLLECT`, `ST_PUBLISH`.
  - Widths `ADC_W`=8, `SUM_W`=16, `CNT_W`=9.
  - Reset constants `MIN_INIT`=255, `MAX_INIT`=0.
- Sub-module `ppg_channel_acc`, instanced once per channel.
  - Inputs: `sample_stb`, `sample`, `clear`, `N`.
  - Outputs: `min`, `max`, `sum`, `full`.
- The top level contains edge detection, the FSM and the output registers.

## Test plan

Run with LOG2_WINDOW=2 (N=4).

- **Reset:** assert `rst_n`=0 mid-window → all outputs 0, `Window_Count`=0. First post-reset window publishes only after 4 fresh samples per channel.
- **Basic window:** RED samples 100,120,110,130 and IR samples 50,50,50,50, controller-style alternation → one `Stats_Valid` pulse with `RED_AC`=30, `RED_DC`=115, `IR_AC`=0, `IR_DC`=50, `Window_Count`=1.
- **Overflow guard:** RED gets 6 samples (200,210,220,230,0,0) before IR's 4th sample → RED uses the first four only: AC=30, DC=215.
- **Full-scale:** 4×255 and 4×0 on the two channels → DC=255 and 0, AC=0 for both, no wrap.
- **Abort:** drop `Stats_En` after 2 samples, re-raise, feed 4 samples of 80 → publish DC=80, AC=0, `Window_Count`=1.
- **Back-to-back and simultaneous:** both LED falling edges in the same cycle, plus a sample exactly in the `PUBLISH` cycle → that sample counts in window 2. `Window_Count` wraps 255→0 after 256 windows.
